// File: rtl/rvfi_order_buffer.sv
// rvfi_order_buffer: reorders out-of-order RVFI commit packets into a single ascending-order stream.
// Ports: in_valid/in_ready/in_order/in_pkt accept tagged commits; out_valid/out_order/out_pkt emit
// them in order with no backpressure; occupancy counts held entries; err_dup/err_stale/err_timeout
// are sticky protocol flags. Defining RVFI_ORDER_BUFFER_STATS_EN adds stat_max_occ,
// stat_stall_cycles and stat_drained plus an end-of-simulation report.
module rvfi_order_buffer #(
  parameter int DEPTH = 16,
  parameter int PKT_W = 328,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [63:0]             in_order,
  input  logic [PKT_W-1:0]        in_pkt,
  output logic                    out_valid,
  output logic [63:0]             out_order,
  output logic [PKT_W-1:0]        out_pkt,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    err_dup,
  output logic                    err_stale,
  output logic                    err_timeout
`ifdef RVFI_ORDER_BUFFER_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]  stat_max_occ,
  output logic [31:0]             stat_stall_cycles,
  output logic [63:0]             stat_drained
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [63:0] head_order, diff;
  logic [DEPTH-1:0] valid;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0] idx, hidx;
  logic [WW-1:0] wd, wd_inc;
  logic [OW-1:0] occ_n;
  logic stale, acc, store, bypass, head_hit, drain, stall, write;
  always_comb begin
    diff = in_order - head_order;
    stale = in_order < head_order;
    in_ready = stale || diff < 64'(DEPTH);
    acc = in_valid && in_ready;
    idx = in_order[AW-1:0];
    hidx = head_order[AW-1:0];
    head_hit = valid[hidx];
    store = acc && !stale && !valid[idx];
    // a head-order packet can only be accepted when its slot is empty, so it goes straight out
    bypass = store && in_order == head_order;
    write = store && !bypass;
    drain = head_hit || bypass;
    stall = occupancy != '0 && !drain;
    occ_n = occupancy + OW'(write) - OW'(head_hit);
    wd_inc = wd + 1'b1;
  end
  always_ff @(posedge clk)
    if (write) mem[idx] <= in_pkt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_order <= '0;
      valid <= '0;
      out_valid <= 1'b0;
      out_order <= '0;
      out_pkt <= '0;
      occupancy <= '0;
      err_dup <= 1'b0;
      err_stale <= 1'b0;
      err_timeout <= 1'b0;
      wd <= '0;
    end else begin
      head_order <= head_order + 64'(drain);
      valid <= (valid | (DEPTH'(write) << idx)) & ~(DEPTH'(head_hit) << hidx);
      out_valid <= drain;
      if (drain) begin
        out_order <= head_order;
        out_pkt <= head_hit ? mem[hidx] : in_pkt;
      end
      occupancy <= occ_n;
      err_dup <= err_dup || (acc && !stale && valid[idx]);
      err_stale <= err_stale || (acc && stale);
      wd <= (!stall || TIMEOUT == 0) ? '0 : wd == WW'(TIMEOUT) ? wd : wd_inc;
      err_timeout <= err_timeout || (TIMEOUT != 0 && stall && wd_inc == WW'(TIMEOUT));
    end
`ifdef RVFI_ORDER_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_max_occ <= '0;
      stat_stall_cycles <= '0;
      stat_drained <= '0;
    end else begin
      if (occ_n > stat_max_occ) stat_max_occ <= occ_n;
      if (stall && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 1'b1;
      stat_drained <= stat_drained + 64'(drain);
    end
  final $display("rvfi_order_buffer stats: max_occ=%0d stall_cycles=%0d drained=%0d",
                 stat_max_occ, stat_stall_cycles, stat_drained);
`endif
endmodule

// File: tb/tb_rvfi_order_buffer.sv
// tb_rvfi_order_buffer: scoreboard bench for the RVFI reorder buffer.
module tb_rvfi_order_buffer;
  localparam int DEPTH = 16;
  localparam int PKT_W = 328;
  localparam int TIMEOUT = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [63:0] in_order = '0;
  logic [PKT_W-1:0] in_pkt = '0;
  logic out_valid;
  logic [63:0] out_order;
  logic [PKT_W-1:0] out_pkt;
  logic [$clog2(DEPTH):0] occupancy;
  logic err_dup, err_stale, err_timeout;
`ifdef RVFI_ORDER_BUFFER_STATS_EN
  logic [$clog2(DEPTH):0] stat_max_occ;
  logic [31:0] stat_stall_cycles;
  logic [63:0] stat_drained;
`endif
  int tests = 0;
  int fails = 0;
  logic [63:0] eq_o [$];
  logic [PKT_W-1:0] eq_p [$];
  rvfi_order_buffer #(.DEPTH(DEPTH), .PKT_W(PKT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_order(in_order), .in_pkt(in_pkt), .out_valid(out_valid), .out_order(out_order),
    .out_pkt(out_pkt), .occupancy(occupancy), .err_dup(err_dup), .err_stale(err_stale),
    .err_timeout(err_timeout)
`ifdef RVFI_ORDER_BUFFER_STATS_EN
    , .stat_max_occ(stat_max_occ), .stat_stall_cycles(stat_stall_cycles),
    .stat_drained(stat_drained)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [PKT_W-1:0] mk(input logic [63:0] o, input logic [7:0] t);
    return {t, o, ~o, o ^ 64'h0123_4567_89ab_cdef, o + 64'd7, o * 64'd3};
  endfunction
  task automatic expect_pkt(input logic [63:0] o, input logic [7:0] t);
    eq_o.push_back(o);
    eq_p.push_back(mk(o, t));
  endtask
  always @(negedge clk)
    if (out_valid) begin
      tests++;
      if (eq_o.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got order %0d, required no output", out_order);
      end else begin
        logic [63:0] eo;
        logic [PKT_W-1:0] ep;
        eo = eq_o.pop_front();
        ep = eq_p.pop_front();
        if (out_order !== eo || out_pkt !== ep) begin
          fails++;
          $display("FAIL scoreboard: got order %0d pkt_tag %0h, required order %0d pkt_tag %0h",
                   out_order, out_pkt[PKT_W-1 -: 8], eo, ep[PKT_W-1 -: 8]);
        end
      end
    end
  task automatic send(input logic [63:0] o, input logic [7:0] t);
    in_valid = 1'b1;
    in_order = o;
    in_pkt = mk(o, t);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_drain(input string name);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 40 && eq_o.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    tests++;
    if (eq_o.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d packets still expected, required 0", name, eq_o.size());
    end
    tests++;
    if (occupancy !== '0) begin
      fails++;
      $display("FAIL %s_occ_end: got %0d, required 0", name, occupancy);
    end
  endtask
  task automatic test_reset();
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_order !== 64'd0 || out_pkt !== '0 || occupancy !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid %b order %0d occ %0d, required 0 0 0",
               out_valid, out_order, occupancy);
    end
    tests++;
    if ({err_dup, err_stale, err_timeout} !== 3'b000) begin
      fails++;
      $display("FAIL reset_errs: got %b, required 000", {err_dup, err_stale, err_timeout});
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_in_order();
    for (int i = 0; i < 8; i++) expect_pkt(64'(i), 8'h10);
    for (int i = 0; i < 8; i++) begin
      send(64'(i), 8'h10);
      tests++;
      if (out_valid !== 1'b1 || out_order !== 64'(i) || occupancy !== '0) begin
        fails++;
        $display("FAIL in_order_step%0d: got valid %b order %0d occ %0d, required 1 %0d 0",
                 i, out_valid, out_order, occupancy, i);
      end
    end
    wait_drain("in_order");
  endtask
  task automatic test_reorder();
    for (int i = 8; i < 12; i++) expect_pkt(64'(i), 8'h20);
    send(64'd11, 8'h20);
    send(64'd9, 8'h20);
    send(64'd10, 8'h20);
    tests++;
    if (out_valid !== 1'b0 || occupancy !== 5'd3) begin
      fails++;
      $display("FAIL reorder_hold: got valid %b occ %0d, required 0 3", out_valid, occupancy);
    end
    send(64'd8, 8'h20);
    for (int i = 8; i < 12; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_order !== 64'(i)) begin
        fails++;
        $display("FAIL reorder_seq%0d: got valid %b order %0d, required 1 %0d",
                 i, out_valid, out_order, i);
      end
      @(posedge clk); #1;
    end
    wait_drain("reorder");
  endtask
  task automatic test_window();
    in_valid = 1'b1;
    in_order = 64'd28;
    in_pkt = mk(64'd28, 8'h30);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0 || occupancy !== '0) begin
        fails++;
        $display("FAIL window_hold%0d: got ready %b occ %0d, required 0 0", i, in_ready, occupancy);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    expect_pkt(64'd12, 8'h30);
    send(64'd12, 8'h30);
    in_order = 64'd28;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL window_open: got ready %b, required 1", in_ready);
    end
    send(64'd28, 8'h30);
    tests++;
    if (occupancy !== 5'd1) begin
      fails++;
      $display("FAIL window_store: got occ %0d, required 1", occupancy);
    end
    for (int i = 13; i < 29; i++) expect_pkt(64'(i), 8'h30);
    for (int i = 13; i < 28; i++) send(64'(i), 8'h30);
    wait_drain("window");
  endtask
  task automatic test_dup();
    send(64'd34, 8'h41);
    tests++;
    if (err_dup !== 1'b0) begin
      fails++;
      $display("FAIL dup_early: got err_dup %b, required 0", err_dup);
    end
    send(64'd34, 8'h42);
    tests++;
    if (err_dup !== 1'b1 || occupancy !== 5'd1) begin
      fails++;
      $display("FAIL dup_flag: got err_dup %b occ %0d, required 1 1", err_dup, occupancy);
    end
    for (int i = 29; i < 34; i++) expect_pkt(64'(i), 8'h40);
    expect_pkt(64'd34, 8'h41);
    for (int i = 29; i < 34; i++) send(64'(i), 8'h40);
    wait_drain("dup");
  endtask
  task automatic test_stale();
    in_valid = 1'b1;
    in_order = 64'd30;
    in_pkt = mk(64'd30, 8'h50);
    #1;
    tests++;
    if (in_ready !== 1'b1 || err_stale !== 1'b0) begin
      fails++;
      $display("FAIL stale_ready: got ready %b err_stale %b, required 1 0", in_ready, err_stale);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (err_stale !== 1'b1 || occupancy !== '0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stale_flag: got err_stale %b occ %0d valid %b, required 1 0 0",
               err_stale, occupancy, out_valid);
    end
    wait_drain("stale");
  endtask
  task automatic test_timeout_reset();
    send(64'd37, 8'h60);
    repeat (7) @(posedge clk);
    #1;
    tests++;
    if (err_timeout !== 1'b0 || occupancy !== 5'd1) begin
      fails++;
      $display("FAIL timeout_early: got err %b occ %0d, required 0 1", err_timeout, occupancy);
    end
    @(posedge clk); #1;
    tests++;
    if (err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_rise: got %b, required 1", err_timeout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_order !== 64'd0 || out_pkt !== '0 || occupancy !== '0 ||
        {err_dup, err_stale, err_timeout} !== 3'b000) begin
      fails++;
      $display("FAIL midreset: got valid %b order %0d occ %0d errs %b, required 0 0 0 000",
               out_valid, out_order, occupancy, {err_dup, err_stale, err_timeout});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_pkt(64'd0, 8'h70);
    send(64'd0, 8'h70);
    tests++;
    if (out_valid !== 1'b1 || out_order !== 64'd0) begin
      fails++;
      $display("FAIL post_reset: got valid %b order %0d, required 1 0", out_valid, out_order);
    end
    wait_drain("post_reset");
  endtask
  initial begin
    test_reset();
    test_in_order();
    test_reorder();
    test_window();
    test_dup();
    test_stale();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
